// File: rtl/smem_arb_pkg.sv
// rtl/smem_arb_pkg.sv - shared widths, tag layout, request record and FSM states for the SMEM arbiter
package smem_arb_pkg;

  localparam int RN_W       = 6;
  localparam int ADDR_W     = 42;
  localparam int FIFO_DEPTH = 8;
  localparam int SKID       = 3;

  localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam int TAG_W       = RN_W + 2;
  localparam int TAG_KL_BIT  = RN_W;
  localparam int TAG_SRC_BIT = RN_W + 1;

  localparam logic SRC_F = 1'b0;
  localparam logic SRC_B = 1'b1;
  localparam logic KL_K  = 1'b0;
  localparam logic KL_L  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SEND_K,
    SEND_L
  } arb_state_t;

  typedef struct packed {
    logic [RN_W-1:0]   read_num;
    logic [ADDR_W-1:0] addr_k;
    logic [ADDR_W-1:0] addr_l;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  function automatic logic [TAG_W-1:0] make_tag(input logic src, input logic kl,
                                                input logic [RN_W-1:0] read_num);
    return {src, kl, read_num};
  endfunction

endpackage

// File: rtl/smem_req_fifo.sv
// rtl/smem_req_fifo.sv - synchronous request FIFO with occupancy count and overflow strobe
module smem_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic             full, do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_pop   = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;
  assign pop_data = mem[rd_ptr];
  assign count    = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/smem_mem_req_arbiter.sv
// rtl/smem_mem_req_arbiter.sv - round-robin sharing of the occurrence-memory port between the
// forward and backward SMEM pipelines, two tagged beats (k then l) per request
module smem_mem_req_arbiter
  import smem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_f,
  input  logic [RN_W-1:0]   read_num_f,
  input  logic [ADDR_W-1:0] addr_k_f,
  input  logic [ADDR_W-1:0] addr_l_f,
  input  logic              req_valid_b,
  input  logic [RN_W-1:0]   read_num_b,
  input  logic [ADDR_W-1:0] addr_k_b,
  input  logic [ADDR_W-1:0] addr_l_b,
  output logic              stall_f,
  output logic              stall_b,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [TAG_W-1:0]  mem_req_tag,
  output logic              overflow_err
);

  req_t             head_f, head_b, entry_q;
  logic [CNT_W-1:0] count_f, count_b;
  logic             empty_f, empty_b, ovf_f, ovf_b;
  logic             last_grant_q, entry_src_q, grant_src, any_req, pop_req;
  arb_state_t       state_q, state_d;

  smem_req_fifo #(.WIDTH(REQ_W), .DEPTH(FIFO_DEPTH)) u_fifo_f (
    .clk       (clk),
    .rst       (rst),
    .push      (req_valid_f),
    .push_data ({read_num_f, addr_k_f, addr_l_f}),
    .pop       (pop_req && grant_src == SRC_F),
    .pop_data  (head_f),
    .count     (count_f),
    .empty     (empty_f),
    .overflow  (ovf_f)
  );

  smem_req_fifo #(.WIDTH(REQ_W), .DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .push      (req_valid_b),
    .push_data ({read_num_b, addr_k_b, addr_l_b}),
    .pop       (pop_req && grant_src == SRC_B),
    .pop_data  (head_b),
    .count     (count_b),
    .empty     (empty_b),
    .overflow  (ovf_b)
  );

  assign any_req   = !empty_f || !empty_b;
  // With both sources waiting, the one not served last wins.
  assign grant_src = (!empty_f && !empty_b) ? ~last_grant_q : (empty_f ? SRC_B : SRC_F);

  always_comb begin
    state_d       = state_q;
    pop_req       = 1'b0;
    mem_req_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          pop_req = 1'b1;
          state_d = SEND_K;
        end
      end
      SEND_K: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = SEND_L;
      end
      SEND_L: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          pop_req = any_req;
          state_d = any_req ? SEND_K : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= SRC_B;
      entry_src_q  <= SRC_F;
      entry_q      <= '0;
      overflow_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop_req) begin
        entry_q      <= (grant_src == SRC_B) ? head_b : head_f;
        entry_src_q  <= grant_src;
        last_grant_q <= grant_src;
      end
      if (ovf_f || ovf_b) overflow_err <= 1'b1;
    end
  end

  assign stall_f = (count_f >= CNT_W'(FIFO_DEPTH - SKID));
  assign stall_b = (count_b >= CNT_W'(FIFO_DEPTH - SKID));

  assign mem_req_addr = (state_q == SEND_K) ? entry_q.addr_k :
                        (state_q == SEND_L) ? entry_q.addr_l : '0;
  assign mem_req_tag  = mem_req_valid ?
                        make_tag(entry_src_q, (state_q == SEND_L) ? KL_L : KL_K, entry_q.read_num) : '0;

endmodule
